// File: rtl/rps_draw_pkg.sv
// Shared types and constants for the rock-paper-scissors framebuffer draw scheduler.
// Holds the FSM encoding, the panel identity, and the colour/choice decode helpers.
package rps_draw_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_USER = 1'b0,
        GNT_COMP = 1'b1
    } panel_t;

    localparam logic [2:0] C_INK     = 3'b010;
    localparam logic [2:0] C_BG_USER = 3'b000;
    localparam logic [2:0] C_BG_COMP = 3'b111;

    localparam logic [1:0] CH_ROCK    = 2'b00;
    localparam logic [1:0] CH_SCISSOR = 2'b01;

    localparam int SCREEN_W = 160;

    // Codes 10 and 11 both mean paper.
    function automatic logic sel_q(input logic [1:0] ch, input logic qr, input logic qs,
                                   input logic qp);
        logic q;
        case (ch)
            CH_ROCK:    q = qr;
            CH_SCISSOR: q = qs;
            default:    q = qp;
        endcase
        return q;
    endfunction

    function automatic logic [2:0] pix_colour(input logic q, input panel_t p);
        logic [2:0] c;
        if (!q)                c = C_INK;
        else if (p == GNT_COMP) c = C_BG_COMP;
        else                   c = C_BG_USER;
        return c;
    endfunction

endpackage

// File: rtl/rps_panel_scanner.sv
// Raster scanner for one panel: local x/y counters, origin offset and the
// full-screen ROM address y*160+x, plus a flag marking the panel's last pixel.
module rps_panel_scanner #(
    parameter int PANEL_W = 80,
    parameter int PANEL_H = 120
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic        step,
    input  logic [7:0]  x_org,
    output logic [7:0]  x_abs,
    output logic [6:0]  y_abs,
    output logic [14:0] rom_addr,
    output logic        last
);

    logic [7:0]  lx;
    logic [6:0]  ly;
    logic [14:0] y15;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            lx <= '0;
            ly <= '0;
        end else if (start) begin
            lx <= '0;
            ly <= '0;
        end else if (step) begin
            if (lx == 8'(PANEL_W - 1)) begin
                lx <= '0;
                ly <= (ly == 7'(PANEL_H - 1)) ? 7'd0 : ly + 7'd1;
            end else begin
                lx <= lx + 8'd1;
            end
        end
    end

    assign x_abs = x_org + lx;
    assign y_abs = ly;
    assign y15   = {8'd0, ly};
    // 160 = 128 + 32, so the multiply collapses to two shifts and an add.
    assign rom_addr = (y15 << 7) + (y15 << 5) + {7'd0, x_abs};
    assign last     = (lx == 8'(PANEL_W - 1)) && (ly == 7'(PANEL_H - 1));

endmodule

// File: rtl/rps_draw_scheduler.sv
// Round-robin scheduler sharing the vga_adapter plot port between the user and
// computer panels; scans the granted panel through the sprite ROMs one pixel per cycle.
module rps_draw_scheduler
    import rps_draw_pkg::*;
#(
    parameter int PANEL_W = 80,
    parameter int PANEL_H = 120,
    parameter int X_USER  = 80,
    parameter int X_COMP  = 0,
    parameter int ROM_LAT = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        req_user,
    input  logic [1:0]  choice_user,
    input  logic        req_comp,
    input  logic [1:0]  choice_comp,
    output logic [14:0] rom_addr,
    input  logic        q_r,
    input  logic        q_s,
    input  logic        q_p,
    output logic        plot,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        busy,
    output logic        done_user,
    output logic        done_comp
);

    localparam int DW = $clog2(ROM_LAT + 1);

    state_t         state, state_nxt;
    panel_t         last_grant, gnt;
    logic           pend_u, pend_c;
    logic [1:0]     choice;
    logic [7:0]     x_org;
    logic [DW-1:0]  drain_cnt;
    logic           grant_u, grant_c, step, last;
    logic [7:0]     x_abs;
    logic [6:0]     y_abs;

    logic [ROM_LAT:1]       vld_pipe;
    logic [ROM_LAT:1][7:0]  x_pipe;
    logic [ROM_LAT:1][6:0]  y_pipe;

    rps_panel_scanner #(
        .PANEL_W (PANEL_W),
        .PANEL_H (PANEL_H)
    ) u_scan (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .start    (grant_u | grant_c),
        .step     (step),
        .x_org    (x_org),
        .x_abs    (x_abs),
        .y_abs    (y_abs),
        .rom_addr (rom_addr),
        .last     (last)
    );

    always_comb begin
        state_nxt = state;
        grant_u   = 1'b0;
        grant_c   = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                // On a tie the panel not served last time wins.
                if (pend_u && (!pend_c || last_grant == GNT_COMP)) begin
                    grant_u   = 1'b1;
                    state_nxt = S_SCAN;
                end else if (pend_c) begin
                    grant_c   = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                step = 1'b1;
                if (last) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (drain_cnt == DW'(ROM_LAT)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= GNT_COMP;
            gnt        <= GNT_USER;
            pend_u     <= 1'b0;
            pend_c     <= 1'b0;
            choice     <= '0;
            x_org      <= '0;
            drain_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            // A request arriving on the grant cycle survives the clear.
            pend_u    <= req_user | (pend_u & ~grant_u);
            pend_c    <= req_comp | (pend_c & ~grant_c);
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (grant_u || grant_c) begin
                gnt        <= grant_c ? GNT_COMP : GNT_USER;
                last_grant <= grant_c ? GNT_COMP : GNT_USER;
                choice     <= grant_c ? choice_comp : choice_user;
                x_org      <= grant_c ? 8'(X_COMP) : 8'(X_USER);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            x_pipe   <= '0;
            y_pipe   <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
        end else begin
            vld_pipe[1] <= step;
            x_pipe[1]   <= x_abs;
            y_pipe[1]   <= y_abs;
            for (int i = 2; i <= ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
            plot   <= vld_pipe[ROM_LAT];
            x      <= vld_pipe[ROM_LAT] ? x_pipe[ROM_LAT] : 8'd0;
            y      <= vld_pipe[ROM_LAT] ? y_pipe[ROM_LAT] : 7'd0;
            colour <= vld_pipe[ROM_LAT] ? pix_colour(sel_q(choice, q_r, q_s, q_p), gnt) : 3'd0;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done_user = (state == S_DONE) && (gnt == GNT_USER);
    assign done_comp = (state == S_DONE) && (gnt == GNT_COMP);

endmodule

// File: tb/tb_rps_draw_scheduler.sv
// Bench for rps_draw_scheduler: ROM stub, pixel/done scoreboard fed by a panel-level
// model of the arbitration, table-driven draws, directed corner sequences, random draws.
module tb_rps_draw_scheduler;

    localparam int PW = 80, PH = 24, XU = 80, XC = 0, RL = 1;
    localparam int NPIX = PW * PH;
    localparam int LAT_EXP = RL + 3;

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct {
        string name; bit rst; bit ru; bit rc;
        logic [1:0] cu; logic [1:0] cc;
        int mode; logic [31:0] seed; int flip; int code;
    } vec_t;

    logic CLOCK_50 = 1'b0, reset_n = 1'b1, req_user = 1'b0, req_comp = 1'b0;
    logic [1:0] choice_user = 2'b00, choice_comp = 2'b00;
    logic [14:0] rom_addr;
    logic q_r = 1'b1, q_s = 1'b1, q_p = 1'b1;
    logic plot, busy, done_user, done_comp;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    rps_draw_scheduler #(.PANEL_W(PW), .PANEL_H(PH), .X_USER(XU), .X_COMP(XC), .ROM_LAT(RL)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req_user(req_user), .choice_user(choice_user),
        .req_comp(req_comp), .choice_comp(choice_comp), .rom_addr(rom_addr),
        .q_r(q_r), .q_s(q_s), .q_p(q_p), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .done_user(done_user), .done_comp(done_comp));

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM stub: which 0=rock 1=scissor 2=paper; mode picks the picture.
    int rom_mode = 0;
    logic [31:0] rom_seed = 32'd0;

    function automatic logic rom_bit(input int which, input int addr);
        logic [31:0] h;
        case (rom_mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (which < 2) ? 1'b1 : (addr == 0);
            default: begin
                h = (32'(addr) * 32'h9E3779B1) ^ rom_seed ^ (32'(which) * 32'h85EBCA6B);
                h = h ^ (h >> 15);
                return h[7];
            end
        endcase
    endfunction

    always @(posedge CLOCK_50) begin
        q_r <= rom_bit(0, int'(rom_addr));
        q_s <= rom_bit(1, int'(rom_addr));
        q_p <= rom_bit(2, int'(rom_addr));
    end

    pix_t exp_q[$];
    int   exp_done[$];
    int   done_q[$];
    int   plots = 0, runs = 0, pix_err = 0;
    logic plot_prev = 1'b0;

    always @(negedge CLOCK_50) begin
        if (reset_n) begin
            if (plot) begin
                plots <= plots + 1;
                if (!plot_prev) runs <= runs + 1;
                if (exp_q.size() == 0) pix_err <= pix_err + 1;
                else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (e.x != int'(x) || e.y != int'(y) || e.c != int'(colour))
                        pix_err <= pix_err + 1;
                end
            end
            if (done_user) done_q.push_back(1);
            if (done_comp) done_q.push_back(2);
        end
        plot_prev <= plot;
    end

    int n_tests = 0, n_fail = 0;
    int p0 = 0, r0 = 0, e0 = 0;
    int last_m = 2;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int code_of(input int q[$]);
        int c = 0;
        foreach (q[i]) c = c * 4 + q[i];
        return c;
    endfunction

    // Expected pixels of one full panel, straight from the drawing rules.
    task automatic push_panel(input int p, input logic [1:0] ch);
        int which;
        which = (ch == 2'b00) ? 0 : (ch == 2'b01) ? 1 : 2;
        for (int yy = 0; yy < PH; yy++) begin
            for (int xx = 0; xx < PW; xx++) begin
                pix_t e;
                logic q;
                e.x = ((p == 2) ? XC : XU) + xx;
                e.y = yy;
                q   = rom_bit(which, e.y * 160 + e.x);
                e.c = q ? ((p == 2) ? 7 : 0) : 2;
                exp_q.push_back(e);
            end
        end
        exp_done.push_back(p);
    endtask

    task automatic model_requests(input bit ru, input bit rc, input logic [1:0] cu,
                                  input logic [1:0] cc);
        if (ru && rc) begin
            if (last_m == 2) begin push_panel(1, cu); push_panel(2, cc); last_m = 2; end
            else             begin push_panel(2, cc); push_panel(1, cu); last_m = 1; end
        end else if (ru) begin push_panel(1, cu); last_m = 1; end
        else if (rc)     begin push_panel(2, cc); last_m = 2; end
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50); #2;
        reset_n = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #2 reset_n = 1'b1;
        exp_q.delete();
        last_m = 2;
    endtask

    task automatic pulse(input bit ru, input bit rc);
        @(posedge CLOCK_50); #1;
        req_user = ru; req_comp = rc;
        @(posedge CLOCK_50); #1;
        req_user = 1'b0; req_comp = 1'b0;
    endtask

    task automatic phase_begin();
        p0 = plots; r0 = runs; e0 = pix_err;
        done_q.delete(); exp_done.delete(); exp_q.delete();
    endtask

    task automatic wait_quiet(input int budget, input int flip_at);
        int quiet = 0, cyc = 0;
        while (quiet < 4 && cyc < budget) begin
            @(posedge CLOCK_50); #1;
            cyc++;
            if (cyc == flip_at) begin
                choice_user = ~choice_user;
                choice_comp = ~choice_comp;
            end
            quiet = busy ? 0 : quiet + 1;
        end
        chk("settle", quiet, 4);
    endtask

    task automatic check_phase(input string name, input int code);
        chk({name, " plots"}, plots - p0, exp_done.size() * NPIX);
        chk({name, " pixel_err"}, pix_err - e0, 0);
        chk({name, " unplotted"}, exp_q.size(), 0);
        chk({name, " runs"}, runs - r0, exp_done.size());
        chk({name, " done_order"}, code_of(done_q), code);
    endtask

    task automatic apply(input vec_t v);
        int lat = 0, blat = 0, code;
        if (v.rst) do_reset();
        rom_mode = v.mode; rom_seed = v.seed;
        choice_user = v.cu; choice_comp = v.cc;
        phase_begin();
        model_requests(v.ru, v.rc, v.cu, v.cc);
        code = (v.code >= 0) ? v.code : code_of(exp_done);
        @(posedge CLOCK_50); #1;
        req_user = v.ru; req_comp = v.rc;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLOCK_50); #1;
            if (k == 1) begin req_user = 1'b0; req_comp = 1'b0; end
            if (busy && blat == 0) blat = k;
            if (plot) begin lat = k; break; end
        end
        chk({v.name, " busy_lat"}, blat, 2);
        chk({v.name, " plot_lat"}, lat, LAT_EXP);
        wait_quiet(3 * NPIX + 200, v.flip);
        check_phase(v.name, code);
    endtask

    initial begin
        vec_t vec [5];
        vec_t rv;
        int cyc, busy_seen;

        vec[0] = '{"user_only", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 0, 32'd0, 0, 1};
        vec[1] = '{"tie_after_user", 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1, 32'd0, 0, 9};
        vec[2] = '{"tie_after_reset", 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1, 32'd0, 0, 6};
        vec[3] = '{"tie_paper_flip", 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 2, 32'd0,
                   NPIX + NPIX / 2, 6};
        vec[4] = '{"comp_hash", 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 3, 32'hA5A5_0101, 500, 2};

        #2 reset_n = 1'b0;
        #1;
        chk("rst plot", int'(plot), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done_user", int'(done_user), 0);
        chk("rst done_comp", int'(done_comp), 0);
        chk("rst x", int'(x), 0);
        chk("rst y", int'(y), 0);
        chk("rst colour", int'(colour), 0);
        chk("rst rom_addr", int'(rom_addr), 0);
        repeat (2) @(posedge CLOCK_50);
        #2 reset_n = 1'b1;
        last_m = 2;

        foreach (vec[i]) apply(vec[i]);

        // Reset in the middle of a user scan with a computer request pending.
        rom_mode = 3; rom_seed = 32'h1234_5678;
        choice_user = 2'b01; choice_comp = 2'b00;
        phase_begin();
        push_panel(1, 2'b01);
        pulse(1'b1, 1'b0);
        cyc = 0;
        while ((plots - p0) < NPIX / 2 && cyc < 3 * NPIX) begin
            @(posedge CLOCK_50); #1;
            cyc++;
            req_comp = (cyc == 300);
        end
        chk("midscan reached", int'((plots - p0) >= NPIX / 2), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst plot", int'(plot), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst x", int'(x), 0);
        chk("midrst colour", int'(colour), 0);
        repeat (3) @(posedge CLOCK_50);
        #2 reset_n = 1'b1;
        exp_q.delete();
        last_m = 2;
        chk("midrst no_done", done_q.size(), 0);
        busy_seen = 0;
        repeat (20) begin
            @(posedge CLOCK_50); #1;
            if (busy) busy_seen++;
        end
        chk("midrst pend_cleared", busy_seen, 0);
        rv = '{"redraw", 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 3, 32'h1234_5678, 0, 1};
        apply(rv);

        // Request for the panel being drawn queues a second full draw.
        rom_mode = 3; rom_seed = 32'h0BAD_CAFE;
        choice_user = 2'b10;
        phase_begin();
        push_panel(1, 2'b10); push_panel(1, 2'b10);
        last_m = 1;
        pulse(1'b1, 1'b0);
        repeat (100) @(posedge CLOCK_50);
        pulse(1'b1, 1'b0);
        wait_quiet(3 * NPIX + 200, 0);
        check_phase("rearm", 5);

        // Request still high on its own grant cycle: set beats clear.
        choice_comp = 2'b01;
        phase_begin();
        push_panel(2, 2'b01); push_panel(2, 2'b01);
        last_m = 2;
        @(posedge CLOCK_50); #1 req_comp = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1 req_comp = 1'b0;
        wait_quiet(3 * NPIX + 200, 0);
        check_phase("set_wins", 10);

        for (int i = 0; i < 4; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rv.name = "rand";
            rv.rst  = 1'b0;
            rv.ru   = pat[0];
            rv.rc   = pat[1];
            rv.cu   = 2'($urandom_range(0, 3));
            rv.cc   = 2'($urandom_range(0, 3));
            rv.mode = 3;
            rv.seed = $urandom;
            rv.flip = (pat == 3) ? 0 : $urandom_range(10, NPIX - 10);
            rv.code = -1;
            apply(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
